// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them
// to instruction memory and releases the core reset once the image checksum matches.
module imem_boot_loader #(
   parameter int AW    = 10,
   parameter int DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_rst,
   output logic          done,
   output logic          error,
   output logic [AW:0]   words_loaded,
   output logic [2:0]    dbg_state
);

   // Handshake: a byte moves when in_valid & in_ready are both 1 at a rising clk edge;
   // in_ready depends only on state (and is forced low during reset).
   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_LOAD = 3'd1,
      S_CSUM = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_byte_idx;
   logic [23:0]   r_shift;
   logic [31:0]   r_n;
   logic [31:0]   r_acc;
   logic [AW:0]   r_cnt;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;

   logic          w_accept_state;
   logic          w_xfer;
   logic          w_word_done;
   logic [31:0]   w_word;
   logic [AW:0]   w_cnt_inc;

   assign w_accept_state = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CSUM);
   assign in_ready       = w_accept_state & rst;
   assign w_xfer         = in_valid & in_ready;
   assign w_word_done    = w_xfer && (r_byte_idx == 2'd3);
   // The first three bytes sit in r_shift; the fourth arrives live on in_data.
   assign w_word         = {in_data, r_shift};
   assign w_cnt_inc      = r_cnt + (AW+1)'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_HDR;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_HDR: begin
            if (w_word_done) begin
               if (w_word == 32'd0)              w_next = S_CSUM;
               else if (w_word > 32'(DEPTH))     w_next = S_ERR;
               else                              w_next = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_word_done && (32'(w_cnt_inc) == r_n)) w_next = S_CSUM;
         end
         S_CSUM: begin
            if (w_word_done) w_next = (w_word == r_acc) ? S_DONE : S_ERR;
         end
         default: w_next = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byte_idx <= 2'd0;
         r_shift    <= 24'd0;
         r_n        <= 32'd0;
         r_acc      <= 32'd0;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'd0;
      end else begin
         r_we <= 1'b0;
         if (w_xfer) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_shift    <= {in_data, r_shift[23:8]};
         end
         if (w_word_done && (r_state == S_HDR)) r_n <= w_word;
         if (w_word_done && (r_state == S_LOAD)) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt[AW-1:0];
            r_wdata <= w_word;
            r_acc   <= r_acc ^ w_word;
            r_cnt   <= w_cnt_inc;
         end
      end
   end

   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign done         = (r_state == S_DONE);
   assign core_rst     = (r_state == S_DONE);
   assign error        = (r_state == S_ERR);
   assign words_loaded = r_cnt;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table, hand-written corner cases
// and random images checked against a byte-stream reference model.
module tb_imem_boot_loader;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;
   localparam int EW    = AW + 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;
   logic [2:0]    dbg_state;

   always #5 clk = ~clk;

   imem_boot_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .dbg_state    (dbg_state)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic [7:0]    tx_q[$];
   int            last_addr = -1;
   int            m_words;
   bit            m_done;
   bit            m_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                     imem_addr, imem_wdata);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("write_addr", 64'(imem_addr), 64'(e[EW-1:32]));
            check("write_data", 64'(imem_wdata), 64'(e[31:0]));
            last_addr = int'(imem_addr);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic push_word(input logic [31:0] w);
      tx_q.push_back(w[7:0]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[31:24]);
   endtask

   function automatic logic [31:0] q_word(input int p);
      return {tx_q[p+3], tx_q[p+2], tx_q[p+1], tx_q[p]};
   endfunction

   // Random image of n words; a bad image has one checksum bit flipped.
   task automatic build_image(input int n, input bit bad);
      logic [31:0] acc;
      logic [31:0] w;
      acc = 32'd0;
      tx_q.delete();
      push_word(32'(n));
      if (n > DEPTH) begin
         for (int i = 0; i < 8; i++) tx_q.push_back(8'($urandom));
         return;
      end
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         push_word(w);
         acc ^= w;
      end
      if (bad) acc ^= (32'd1 << $urandom_range(0, 31));
      push_word(acc);
   endtask

   // Reference model: parses the queued stream into expected writes and outcome.
   task automatic run_model();
      logic [31:0] n;
      logic [31:0] acc;
      logic [31:0] w;
      int          p;
      m_words = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      acc     = 32'd0;
      if (tx_q.size() < 4) return;
      n = q_word(0);
      if (n > 32'(DEPTH)) begin
         m_err = 1'b1;
         return;
      end
      p = 4;
      for (int i = 0; i < int'(n); i++) begin
         if (p + 4 > tx_q.size()) return;
         w = q_word(p);
         exp_q.push_back({AW'(i), w});
         acc ^= w;
         m_words++;
         p += 4;
      end
      if (p + 4 <= tx_q.size()) begin
         if (q_word(p) == acc) m_done = 1'b1;
         else                  m_err  = 1'b1;
      end
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      if (chk) begin
         check("rst_in_ready", 64'(in_ready), 64'd0);
         check("rst_imem_we", 64'(imem_we), 64'd0);
         check("rst_imem_addr", 64'(imem_addr), 64'd0);
         check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
         check("rst_core_rst", 64'(core_rst), 64'd0);
         check("rst_done", 64'(done), 64'd0);
         check("rst_error", 64'(error), 64'd0);
         check("rst_words_loaded", 64'(words_loaded), 64'd0);
      end
      exp_q.delete();
      last_addr = -1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
   // Returns on the falling edge after the last accepted byte.
   task automatic send_all(input int mode);
      bit toggle;
      int budget;
      toggle = 1'b0;
      budget = 4 * tx_q.size() + 200;
      while (tx_q.size() > 0) begin
         @(negedge clk);
         if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_budget: got %0d bytes left expected 0", tx_q.size());
            break;
         end
         budget--;
         if (!in_ready) break;
         if ((mode == 1 && toggle) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
            toggle   = 1'b0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            continue;
         end
         toggle   = 1'b1;
         in_valid = 1'b1;
         in_data  = tx_q.pop_front();
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      tx_q.delete();
   endtask

   task automatic check_final(input bit e_done, input bit e_err, input int e_words);
      check("final_done", 64'(done), 64'(e_done));
      check("final_error", 64'(error), 64'(e_err));
      check("final_core_rst", 64'(core_rst), 64'(e_done));
      check("final_in_ready", 64'(in_ready), 64'(!(e_done || e_err)));
      check("final_words_loaded", 64'(words_loaded), 64'(e_words));
      check("pending_writes", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load_example(input logic [7:0] csum_lo, input int mode, input int upto);
      logic [7:0] img[16];
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00};
      img[12] = csum_lo;
      tx_q.delete();
      for (int i = 0; i < upto; i++) tx_q.push_back(img[i]);
      exp_q.push_back({AW'(0), 32'h0000_0013});
      if (upto >= 12) exp_q.push_back({AW'(1), 32'h0050_0093});
      send_all(mode);
   endtask

   typedef struct {
      int n;
      bit bad;
      int mode;
      bit exp_done;
      bit exp_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{n: 2,    bad: 1'b0, mode: 0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[1] = '{n: 2,    bad: 1'b1, mode: 0, exp_done: 1'b0, exp_err: 1'b1};
      vecs[2] = '{n: 0,    bad: 1'b0, mode: 0, exp_done: 1'b1, exp_err: 1'b0};
      vecs[3] = '{n: 0,    bad: 1'b1, mode: 1, exp_done: 1'b0, exp_err: 1'b1};
      vecs[4] = '{n: 5,    bad: 1'b0, mode: 1, exp_done: 1'b1, exp_err: 1'b0};
      vecs[5] = '{n: 1,    bad: 1'b0, mode: 2, exp_done: 1'b1, exp_err: 1'b0};
      vecs[6] = '{n: 3,    bad: 1'b1, mode: 2, exp_done: 1'b0, exp_err: 1'b1};
      vecs[7] = '{n: 1025, bad: 1'b0, mode: 0, exp_done: 1'b0, exp_err: 1'b1};

      // Normal example image, back-to-back.
      do_reset(1'b1);
      load_example(8'h80, 0, 16);
      check_final(1'b1, 1'b0, 2);
      // Bytes offered while not ready must be ignored.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("ignored_done", 64'(done), 64'd1);
      check("ignored_words", 64'(words_loaded), 64'd2);

      // Same image with the source stalling every other cycle.
      do_reset(1'b0);
      load_example(8'h80, 1, 16);
      check_final(1'b1, 1'b0, 2);

      // Bad checksum.
      do_reset(1'b0);
      load_example(8'h81, 0, 16);
      check_final(1'b0, 1'b1, 2);

      // Empty image.
      do_reset(1'b0);
      tx_q.delete();
      for (int i = 0; i < 8; i++) tx_q.push_back(8'h00);
      send_all(0);
      check_final(1'b1, 1'b0, 0);

      // Oversize header only: error right after the 4th header byte.
      do_reset(1'b0);
      tx_q.delete();
      push_word(32'h0000_0401);
      send_all(0);
      check_final(1'b0, 1'b1, 0);

      // Reset after the 2nd byte of word 1, then a clean load from address 0.
      do_reset(1'b0);
      load_example(8'h80, 0, 10);
      check("midload_words", 64'(words_loaded), 64'd1);
      check("midload_core_rst", 64'(core_rst), 64'd0);
      do_reset(1'b1);
      load_example(8'h80, 0, 16);
      check_final(1'b1, 1'b0, 2);

      // Vector table.
      for (int v = 0; v < 8; v++) begin
         do_reset(1'b0);
         build_image(vecs[v].n, vecs[v].bad);
         run_model();
         send_all(vecs[v].mode);
         check_final(vecs[v].exp_done, vecs[v].exp_err, m_words);
      end

      // Random images against the reference model.
      for (int r = 0; r < 8; r++) begin
         do_reset(1'b0);
         build_image($urandom_range(0, 12), $urandom_range(0, 3) == 0);
         run_model();
         send_all($urandom_range(0, 2));
         check_final(m_done, m_err, m_words);
      end

      // Full-capacity image.
      do_reset(1'b0);
      build_image(DEPTH, 1'b0);
      run_model();
      send_all(0);
      check_final(1'b1, 1'b0, DEPTH);
      check("capacity_last_addr", 64'(last_addr), 64'(DEPTH - 1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Writer side of the instruction memory: receives a program image as a byte stream over a valid/ready handshake and writes it word-by-word into the instruction memory write port. Holds the pipeline core in reset until the complete image has been written and its checksum verified, then releases it. Sits between the off-chip/testbench byte source and the instruction memory plus the core reset input.

Parameters:
AW, 10, instruction memory word-address width
DEPTH, 1024, instruction memory capacity in 32-bit words (must be <= 2**AW)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready at clk edge
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  AW  word address of the write
imem_wdata  output  32  word written
core_rst  output  1  active-low reset to pipeline; 0 = core held in reset
done  output  1  image loaded and checksum good (sticky)
error  output  1  image rejected (sticky)
words_loaded  output  AW+1  count of words written so far

Behaviour:
- Clock and reset: one clock, clk; reset is rst, asynchronous, active-low.
- Reset (rst=0, asynchronous): state=HDR, byte index=0, word counter=0, checksum accumulator=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, error=0, words_loaded=0. in_ready=0 while rst=0.
- Byte assembly: little-endian; byte 0 -> bits [7:0], byte 3 -> bits [31:24]. 2-bit byte index advances only on an accepted transfer; no-transfer cycles (in_valid=0) leave all state unchanged.
- States:
  - HDR: in_ready=1. Collect 4-byte word count N. After the 4th byte: N=0 -> CSUM; N>DEPTH -> ERR; else -> LOAD.
  - LOAD: in_ready=1. After the 4th byte of each word, at the same edge: register imem_wdata=word, imem_addr=word counter, imem_we=1 (visible the following cycle, exactly one cycle), XOR the word into the accumulator, increment word counter and words_loaded. When the counter reaches N -> CSUM.
  - CSUM: in_ready=1. Collect a 4-byte checksum word. Equal to the XOR of all N words (0 when N=0) -> DONE, else -> ERR.
  - DONE: in_ready=0, done=1, core_rst=1 from the cycle after the final checksum byte. Terminal.
  - ERR: in_ready=0, error=1, core_rst stays 0. Terminal.
- DONE and ERR are left only via rst. done and error are never both 1.
- in_ready is a decode of state only. It drops in the cycle after the last accepted byte, so no extra byte is consumed.
- imem_we is 0 in all cycles except the write pulse. imem_addr and imem_wdata hold their last value between pulses.
- Bytes presented while in_ready=0 are ignored and have no effect.
- Reset mid-load: all state is cleared, core_rst returns to 0 immediately, and the next image starts at HDR with address 0. Words already written to memory are not erased.
- Width rules: N is a full 32-bit compare against DEPTH. The word counter is AW+1 bits, so N=DEPTH loads addresses 0..DEPTH-1 without wrap.

Test Plan:
- Normal load: stream 02 00 00 00 | 13 00 00 00 | 93 00 50 00 | 80 00 50 00 with in_valid held 1 -> imem_we pulses with (addr 0, 0x00000013) then (addr 1, 0x00500093); done=1, core_rst=1 one cycle after the last byte; words_loaded=2; in_ready=0 afterwards.
- Stalled source: same image with in_valid toggled 1/0 every cycle -> identical writes and final state; no byte duplicated or skipped.
- Bad checksum: same image with checksum bytes 81 00 50 00 -> both words written, then error=1, done=0, core_rst stays 0, in_ready=0.
- Empty and oversize count: header 00 00 00 00 then checksum 00 00 00 00 -> done=1 with no imem_we pulse. Header 01 04 00 00 (N=1025 > DEPTH) -> error=1 immediately after the header, no write.
- Reset mid-load: assert rst=0 after the 2nd byte of word 1 -> core_rst=0 and all outputs at reset values. After release, a full valid image loads from addr 0 and ends with done=1.
- Capacity boundary: N=1024 words with matching checksum -> last write at addr 1023, words_loaded=1024, done=1.
